// File: rtl/cotm32_pkg.sv
// cotm32_pkg: shared types for the registered decode stage.
//   Control bundle (cu_ctrl_t), its reset/bubble value CU_CTRL_NOP, the decode
//   stage FSM states, opcode / funct constants and the ALU op mapping helpers.
package cotm32_pkg;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } alu_op_t;

   typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
   typedef enum logic       {ALU_B_RS2, ALU_B_IMM} alu_b_sel_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
   typedef enum logic [1:0] {BU_NEVER, BU_ALWAYS, BU_COND} bu_be_t;
   typedef enum logic [3:0] {
      LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
   } lsu_ls_t;
   typedef enum logic [1:0] {WB_ALU, WB_LSU, WB_PC4, WB_CSR} reg_wb_sel_t;
   typedef enum logic       {CSR_SRC_RS1, CSR_SRC_ZIMM} csr_data_sel_t;

   typedef enum logic [1:0] {S_RUN, S_WFI, S_FENCEI} cu_state_t;

   typedef struct packed {
      alu_op_t       alu_op;
      alu_a_sel_t    alu_a_sel;
      alu_b_sel_t    alu_b_sel;
      imm_sel_t      imm_sel;
      bu_be_t        bu_be;
      logic [2:0]    bu_op;          // branch compare kind (funct3)
      logic          regfile_we;
      logic [4:0]    rd;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      lsu_ls_t       lsu_ls;
      reg_wb_sel_t   reg_wb_sel;
      logic          csr_we;
      logic [1:0]    csr_op;         // 01 RW, 10 RS, 11 RC
      csr_data_sel_t csr_data_sel;
      logic [11:0]   csr_addr;
      logic [4:0]    csr_zimm;
      logic          mret;
      logic          wfi;
      logic          fencei;
      logic          trap_illegal;
      logic          trap_ecall_m;
      logic          trap_ebreak;
   } cu_ctrl_t;

   localparam cu_ctrl_t CU_CTRL_NOP = '{
      alu_op: ALU_ADD, alu_a_sel: ALU_A_RS1, alu_b_sel: ALU_B_RS2, imm_sel: IMM_I,
      bu_be: BU_NEVER, bu_op: 3'd0, regfile_we: 1'b0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
      lsu_ls: LSU_NONE, reg_wb_sel: WB_ALU, csr_we: 1'b0, csr_op: 2'd0,
      csr_data_sel: CSR_SRC_RS1, csr_addr: 12'd0, csr_zimm: 5'd0, mret: 1'b0,
      wfi: 1'b0, fencei: 1'b0, trap_illegal: 1'b0, trap_ecall_m: 1'b0,
      trap_ebreak: 1'b0
   };

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [31:0] INST_EXACT_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EXACT_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_EXACT_MRET   = 32'h3020_0073;
   localparam logic [31:0] INST_EXACT_WFI    = 32'h1050_0073;

   // Base integer op; alt selects SUB/SRA (funct7 bit 5).
   function automatic alu_op_t alu_base_op(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_t alu_m_op(input logic [2:0] f3);
      alu_op_t op;
      case (f3)
         F3_MUL:    op = ALU_MUL;
         F3_MULH:   op = ALU_MULH;
         F3_MULHSU: op = ALU_MULHSU;
         F3_MULHU:  op = ALU_MULHU;
         F3_DIV:    op = ALU_DIV;
         F3_DIVU:   op = ALU_DIVU;
         F3_REM:    op = ALU_REM;
         default:   op = ALU_REMU;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational RV32I (+M, Zicsr, FENCE/FENCE.I, MRET, WFI) decoder.
//   i_inst  [31:0]  instruction word
//   o_ctrl          decoded control bundle (cu_ctrl_t)
// Illegal encodings produce a NOP bundle with trap_illegal set.
module cu_decode
   import cotm32_pkg::*;
#(
   parameter bit EN_M     = 1'b1,
   parameter bit EN_ZICSR = 1'b1,
   parameter bit EN_WFI   = 1'b1
) (
   input  logic [31:0] i_inst,
   output cu_ctrl_t    o_ctrl
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   cu_ctrl_t   ctrl;
   logic       illegal;

   assign opcode = i_inst[6:0];
   assign rd     = i_inst[11:7];
   assign funct3 = i_inst[14:12];
   assign rs1    = i_inst[19:15];
   assign rs2    = i_inst[24:20];
   assign funct7 = i_inst[31:25];

   always_comb begin
      ctrl     = CU_CTRL_NOP;
      illegal  = 1'b0;
      ctrl.rd  = rd;
      ctrl.rs1 = rs1;
      ctrl.rs2 = rs2;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            ctrl.regfile_we = 1'b1;
            ctrl.alu_a_sel  = (opcode == OPC_LUI) ? ALU_A_ZERO : ALU_A_PC;
            ctrl.alu_b_sel  = ALU_B_IMM;
            ctrl.imm_sel    = IMM_U;
         end
         OPC_JAL: begin
            ctrl.regfile_we = 1'b1;
            ctrl.alu_a_sel  = ALU_A_PC;
            ctrl.alu_b_sel  = ALU_B_IMM;
            ctrl.imm_sel    = IMM_J;
            ctrl.bu_be      = BU_ALWAYS;
            ctrl.reg_wb_sel = WB_PC4;
         end
         OPC_JALR: begin
            illegal         = (funct3 != 3'b000);
            ctrl.regfile_we = 1'b1;
            ctrl.alu_b_sel  = ALU_B_IMM;
            ctrl.bu_be      = BU_ALWAYS;
            ctrl.reg_wb_sel = WB_PC4;
         end
         OPC_BRANCH: begin
            illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
            ctrl.alu_a_sel = ALU_A_PC;
            ctrl.alu_b_sel = ALU_B_IMM;
            ctrl.imm_sel   = IMM_B;
            ctrl.bu_be     = BU_COND;
            ctrl.bu_op     = funct3;
         end
         OPC_LOAD: begin
            ctrl.regfile_we = 1'b1;
            ctrl.reg_wb_sel = WB_LSU;
            ctrl.alu_b_sel  = ALU_B_IMM;
            case (funct3)
               3'b000:  ctrl.lsu_ls = LSU_LB;
               3'b001:  ctrl.lsu_ls = LSU_LH;
               3'b010:  ctrl.lsu_ls = LSU_LW;
               3'b100:  ctrl.lsu_ls = LSU_LBU;
               3'b101:  ctrl.lsu_ls = LSU_LHU;
               default: illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            ctrl.alu_b_sel = ALU_B_IMM;
            ctrl.imm_sel   = IMM_S;
            case (funct3)
               3'b000:  ctrl.lsu_ls = LSU_SB;
               3'b001:  ctrl.lsu_ls = LSU_SH;
               3'b010:  ctrl.lsu_ls = LSU_SW;
               default: illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            ctrl.regfile_we = 1'b1;
            ctrl.alu_b_sel  = ALU_B_IMM;
            ctrl.alu_op     = alu_base_op(funct3, 1'b0);
            // Only the shift-immediates constrain the upper bits.
            if (funct3 == 3'b001)
               illegal = (funct7 != F7_BASE);
            else if (funct3 == 3'b101) begin
               ctrl.alu_op = alu_base_op(funct3, funct7 == F7_ALT);
               illegal     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
         end
         OPC_OP: begin
            ctrl.regfile_we = 1'b1;
            if (funct7 == F7_BASE)
               ctrl.alu_op = alu_base_op(funct3, 1'b0);
            else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
               ctrl.alu_op = alu_base_op(funct3, 1'b1);
            else if ((funct7 == F7_M) && EN_M)
               ctrl.alu_op = alu_m_op(funct3);
            else
               illegal = 1'b1;
         end
         OPC_MISC_MEM: begin
            case (funct3)
               3'b000:  ;                    // FENCE: in-order core, nothing to do
               3'b001:  ctrl.fencei = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            if (funct3 == 3'b000) begin
               if (i_inst == INST_EXACT_ECALL)       ctrl.trap_ecall_m = 1'b1;
               else if (i_inst == INST_EXACT_EBREAK) ctrl.trap_ebreak  = 1'b1;
               else if (i_inst == INST_EXACT_MRET)   ctrl.mret         = 1'b1;
               else if (i_inst == INST_EXACT_WFI)    ctrl.wfi          = EN_WFI;
               else                                  illegal           = 1'b1;
            end else if ((funct3 == 3'b100) || !EN_ZICSR) begin
               illegal = 1'b1;
            end else begin
               ctrl.regfile_we   = 1'b1;
               ctrl.reg_wb_sel   = WB_CSR;
               ctrl.csr_op       = funct3[1:0];
               ctrl.csr_data_sel = funct3[2] ? CSR_SRC_ZIMM : CSR_SRC_RS1;
               ctrl.csr_addr     = i_inst[31:20];
               ctrl.csr_zimm     = rs1;
               // Set/clear with a zero source (rs1 or zimm share the field) is read-only.
               ctrl.csr_we       = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
            end
         end
         default: illegal = 1'b1;
      endcase

      if (rd == 5'd0) ctrl.regfile_we = 1'b0;

      if (illegal) begin
         ctrl              = CU_CTRL_NOP;
         ctrl.trap_illegal = 1'b1;
      end
   end

   assign o_ctrl = ctrl;

endmodule

// File: rtl/cu_pipe.sv
// cu_pipe: registered decode stage between fetch and execute.
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_inst_valid/o_inst_ready, i_inst, i_pc   fetch side
//   o_valid/i_ready, o_ctrl, o_pc             execute side
//   i_flush                  kill held entry and abort any stall
//   i_irq_pending            wakes a WFI stall
//   i_pipe_empty             downstream idle, lets FENCE.I complete
//   o_fencei_req             one-cycle I-cache/fetch invalidate pulse
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready; ctrl/pc hold while valid && !ready.
// Accept and retire on the same edge replace the held entry with the new one.
module cu_pipe
   import cotm32_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit EN_M     = 1'b1,
   parameter bit EN_ZICSR = 1'b1,
   parameter bit EN_WFI   = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_inst_valid,
   output logic                       o_inst_ready,
   input  logic [31:0]                i_inst,
   input  logic [XLEN-1:0]            i_pc,
   input  logic                       i_flush,
   input  logic                       i_irq_pending,
   input  logic                       i_pipe_empty,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$bits(cu_ctrl_t)-1:0] o_ctrl,
   output logic [XLEN-1:0]            o_pc,
   output logic                       o_fencei_req
);

   cu_state_t       state_q, state_d;
   logic            valid_q, valid_d;
   cu_ctrl_t        ctrl_q;
   logic [XLEN-1:0] pc_q;
   cu_ctrl_t        dec_ctrl;
   logic            accept;
   logic            retire;
   logic            fencei_req;

   cu_decode #(
      .EN_M     (EN_M),
      .EN_ZICSR (EN_ZICSR),
      .EN_WFI   (EN_WFI)
   ) u_decode (
      .i_inst (i_inst),
      .o_ctrl (dec_ctrl)
   );

   assign o_inst_ready = (state_q == S_RUN) && (!valid_q || i_ready) && !i_flush;
   assign accept       = i_inst_valid && o_inst_ready;
   assign retire       = valid_q && i_ready;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      fencei_req = 1'b0;
      if (retire) valid_d = 1'b0;
      if (accept) valid_d = 1'b1;
      case (state_q)
         S_RUN: begin
            if (accept && dec_ctrl.wfi)         state_d = S_WFI;
            else if (accept && dec_ctrl.fencei) state_d = S_FENCEI;
         end
         S_WFI: begin
            if (i_irq_pending) state_d = S_RUN;
         end
         S_FENCEI: begin
            // Wait for the FENCE.I bundle itself to leave and downstream to drain.
            if (!valid_q && i_pipe_empty) begin
               state_d    = S_RUN;
               fencei_req = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
      if (i_flush) begin
         valid_d    = 1'b0;
         state_d    = S_RUN;
         fencei_req = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_RUN;
         valid_q <= 1'b0;
         ctrl_q  <= CU_CTRL_NOP;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         if (accept) begin
            ctrl_q <= dec_ctrl;
            pc_q   <= i_pc;
         end
      end
   end

   assign o_valid      = valid_q;
   assign o_ctrl       = ctrl_q;
   assign o_pc         = pc_q;
   assign o_fencei_req = fencei_req;

endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: directed bench for cu_pipe (EN_M=1 instance plus an EN_M=0 instance).
module tb_cu_pipe;
  import cotm32_pkg::*;

  localparam int XLEN = 32;
  localparam int CW   = $bits(cu_ctrl_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            irq;
  logic            pipe_empty;
  logic            valid;
  logic            rdy;
  logic [CW-1:0]   ctrl_w;
  logic [XLEN-1:0] opc;
  logic            fencei_req;
  logic            nom_inst_ready;
  logic            nom_valid;
  logic [CW-1:0]   nom_ctrl_w;
  logic [XLEN-1:0] nom_pc;
  logic            nom_fencei_req;
  cu_ctrl_t        c;
  cu_ctrl_t        nc;

  assign c  = ctrl_w;
  assign nc = nom_ctrl_w;

  cu_pipe #(.XLEN(XLEN), .EN_M(1'b1), .EN_ZICSR(1'b1), .EN_WFI(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
    .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_irq_pending(irq),
    .i_pipe_empty(pipe_empty), .o_valid(valid), .i_ready(rdy), .o_ctrl(ctrl_w),
    .o_pc(opc), .o_fencei_req(fencei_req)
  );

  cu_pipe #(.XLEN(XLEN), .EN_M(1'b0), .EN_ZICSR(1'b1), .EN_WFI(1'b1)) dut_nom (
    .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .o_inst_ready(nom_inst_ready),
    .i_inst(inst), .i_pc(pc), .i_flush(flush), .i_irq_pending(irq),
    .i_pipe_empty(pipe_empty), .o_valid(nom_valid), .i_ready(rdy), .o_ctrl(nom_ctrl_w),
    .o_pc(nom_pc), .o_fencei_req(nom_fencei_req)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_bad = 0;
  int n_pulse = 0;
  int p0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  always @(posedge clk) if (fencei_req) n_pulse <= n_pulse + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] w, input logic [31:0] a);
    inst_valid = 1'b1;
    inst       = w;
    pc         = a;
  endtask

  task automatic idle();
    inst_valid = 1'b0;
  endtask

  // ---------------- vectors ----------------
  // ADDI x1,x0,5 / SUB x4,x2,x3 / LW x5,8(x1) / SW x5,12(x1) / BEQ x1,x2,+8
  logic [31:0] s_inst [5] = '{32'h00500093, 32'h40310233, 32'h0080A283, 32'h0050A623, 32'h00208463};
  logic        s_we   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  lsu_ls_t     s_lsu  [5] = '{LSU_NONE, LSU_NONE, LSU_LW, LSU_SW, LSU_NONE};
  bu_be_t      s_bu   [5] = '{BU_NEVER, BU_NEVER, BU_NEVER, BU_NEVER, BU_COND};
  alu_op_t     s_alu  [3] = '{ALU_ADD, ALU_SUB, ALU_ADD};

  // MUL, DIVU, REMU, unknown opcode, bad funct7, MISC-MEM f3=2,
  // CSRRS x5,mstatus,x0, CSRRW x5,mstatus,x1, ADDI x0,x0,1, ECALL
  logic [31:0] d_inst [10] = '{32'h022081B3, 32'h0220D1B3, 32'h0220F1B3, 32'h0000007F,
                               32'h420081B3, 32'h0000200F, 32'h300022F3, 32'h300092F3,
                               32'h00100013, 32'h00000073};
  logic        d_ill  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        d_we   [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  alu_op_t     d_alu  [3]  = '{ALU_MUL, ALU_DIVU, ALU_REMU};

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0;
    irq = 1'b0; pipe_empty = 1'b1; rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    settle();
    check("rst_valid", valid, 0);
    check("rst_ctrl", ctrl_w, CU_CTRL_NOP);
    check("rst_lsu", c.lsu_ls, LSU_NONE);
    check("rst_bu", c.bu_be, BU_NEVER);
    check("rst_pc", opc, 0);
    check("rst_fencei", fencei_req, 0);
    check("rst_ready", inst_ready, 1);

    // back-to-back stream
    for (int k = 0; k < 5; k++) begin
      present(s_inst[k], 32'h100 + 32'(4 * k));
      #1;
      check("s_ready", inst_ready, 1);
      step();
      exp_q.push_back(32'h100 + 32'(4 * k));
      settle();
      check("s_valid", valid, 1);
      exp_pc = exp_q.pop_front();
      check("s_pc", opc, exp_pc);
      check("s_we", c.regfile_we, s_we[k]);
      check("s_lsu", c.lsu_ls, s_lsu[k]);
      check("s_bu", c.bu_be, s_bu[k]);
      if (k < 3) check("s_alu", c.alu_op, s_alu[k]);
      if (k == 0) begin
        check("addi_rd", c.rd, 1);
        check("addi_imm", c.imm_sel, IMM_I);
      end
    end
    idle();
    step();
    settle();
    check("s_drain", valid, 0);

    // backpressure
    present(32'h00700313, 32'h200);
    step();
    rdy = 1'b0;
    present(32'h00900393, 32'h204);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_ready", inst_ready, 0);
      check("bp_valid", valid, 1);
      check("bp_pc", opc, 32'h200);
      check("bp_rd", c.rd, 6);
      step();
    end
    rdy = 1'b1;
    settle();
    check("bp_release", inst_ready, 1);
    step();
    idle();
    settle();
    check("bp_next_pc", opc, 32'h204);
    check("bp_next_rd", c.rd, 7);
    step();
    settle();
    check("bp_empty", valid, 0);

    // decode table
    for (int k = 0; k < 10; k++) begin
      present(d_inst[k], 32'h500 + 32'(4 * k));
      step();
      idle();
      settle();
      check("d_valid", valid, 1);
      check("d_illegal", c.trap_illegal, d_ill[k]);
      check("d_we", c.regfile_we, d_we[k]);
      if (k < 3) check("d_alu", c.alu_op, d_alu[k]);
      if (k == 0) begin
        check("nom_valid", nom_valid, 1);
        check("nom_illegal", nc.trap_illegal, 1);
        check("nom_we", nc.regfile_we, 0);
      end
      if (k == 6) check("csrrs_x0_we", c.csr_we, 0);
      if (k == 7) check("csrrw_we", c.csr_we, 1);
      if (k == 9) check("ecall", c.trap_ecall_m, 1);
    end
    step();

    // WFI, wake four cycles later
    settle();
    present(32'h10500073, 32'h300);
    step();
    present(32'h00500093, 32'h304);
    settle();
    check("wfi_valid", valid, 1);
    check("wfi_flag", c.wfi, 1);
    check("wfi_we", c.regfile_we, 0);
    check("wfi_ready", inst_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      settle();
      check("wfi_stall", inst_ready, 0);
    end
    step();
    irq = 1'b1;
    settle();
    check("wfi_irq_edge", inst_ready, 0);
    step();
    irq = 1'b0;
    settle();
    check("wfi_wake", inst_ready, 1);
    step();
    idle();
    settle();
    check("wfi_next_valid", valid, 1);
    check("wfi_next_pc", opc, 32'h304);

    // WFI with IRQ already pending still stalls one cycle
    irq = 1'b1;
    present(32'h10500073, 32'h310);
    step();
    idle();
    settle();
    check("wfi_irq_same", inst_ready, 0);
    step();
    irq = 1'b0;
    settle();
    check("wfi_irq_same_wake", inst_ready, 1);

    // FENCE.I with downstream busy
    pipe_empty = 1'b0;
    p0 = n_pulse;
    present(32'h0000100F, 32'h400);
    step();
    idle();
    settle();
    check("fi_valid", valid, 1);
    check("fi_flag", c.fencei, 1);
    check("fi_ready", inst_ready, 0);
    check("fi_req0", fencei_req, 0);
    step();
    settle();
    check("fi_retired", valid, 0);
    check("fi_req1", fencei_req, 0);
    step();
    settle();
    check("fi_req2", fencei_req, 0);
    step();
    pipe_empty = 1'b1;
    settle();
    check("fi_req_pulse", fencei_req, 1);
    step();
    settle();
    check("fi_req_after", fencei_req, 0);
    check("fi_ready_after", inst_ready, 1);
    check("fi_pulse_count", n_pulse - p0, 1);

    // flush during FENCE.I with the entry still held
    rdy = 1'b0;
    present(32'h0000100F, 32'h410);
    step();
    idle();
    p0 = n_pulse;
    settle();
    check("fl_valid", valid, 1);
    check("fl_ready", inst_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    check("fl_valid_after", valid, 0);
    check("fl_run", inst_ready, 1);
    step();
    settle();
    check("fl_no_pulse", n_pulse - p0, 0);
    rdy = 1'b1;

    // flush wins over a same-cycle accept
    present(32'h00500093, 32'h420);
    flush = 1'b1;
    #1;
    check("fl_acc_ready", inst_ready, 0);
    step();
    flush = 1'b0;
    idle();
    settle();
    check("fl_acc_valid", valid, 0);

    // reset in the middle of a WFI stall
    present(32'h10500073, 32'h430);
    step();
    idle();
    settle();
    check("rs_stall", inst_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("rs_valid", valid, 0);
    check("rs_ready", inst_ready, 1);
    check("rs_req", fencei_req, 0);
    check("rs_pc", opc, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_pipe.md
Name: cu_pipe

Overview:
- Registered decode stage between fetch and execute; successor to the combinational control unit.
- Decodes RV32I plus optional M, Zicsr, FENCE/FENCE.I, MRET and WFI into a packed control bundle, one instruction per cycle.
- Valid/ready handshake on both sides; pipeline flush; FSM stalls decode for WFI and FENCE.I drain.

Parameters:
- XLEN, 32, datapath/PC width.
- EN_M, 1, decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 makes them illegal.
- EN_ZICSR, 1, decode CSR instructions; 0 makes funct3!=0 SYSTEM illegal.
- EN_WFI, 1, WFI stalls; 0 treats WFI as NOP.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_inst_valid  in  1  fetch presents instruction
- o_inst_ready  out  1  stage accepts instruction
- i_inst  in  32  instruction word
- i_pc  in  XLEN  instruction PC
- i_flush  in  1  kill held entry, abort stall
- i_irq_pending  in  1  any enabled interrupt pending (WFI wake)
- i_pipe_empty  in  1  downstream stages and store buffer idle
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  execute accepts bundle
- o_ctrl  out  $bits(cu_ctrl_t)  decoded control bundle
- o_pc  out  XLEN  PC of held instruction
- o_fencei_req  out  1  one-cycle I-cache/fetch invalidate pulse

Behaviour:
- Reset: o_valid=0; o_ctrl=CU_CTRL_NOP (all enables 0, lsu LSU_NONE, bu BU_NEVER, alu ALU_ADD, all trap flags 0); o_pc=0; o_fencei_req=0; FSM=S_RUN.
- Latency 1: bundle registered on the accept edge; back-to-back throughput 1/cycle.
- o_inst_ready = (state==S_RUN) && (!o_valid || i_ready) && !i_flush, combinational.
- Accept = i_inst_valid && o_inst_ready. Held entry retires when o_valid && i_ready. Accept and retire in the same cycle: new entry replaces old.
- o_ctrl and o_pc are stable while o_valid && !i_ready.
- Flush is highest priority: next cycle o_valid=0, FSM=S_RUN, and no fencei pulse is issued. Flush overrides any same-cycle accept.
- Illegal encodings (unknown opcode, bad funct3/funct7, disabled extension, MISC-MEM funct3 other than 0/1) pass through as a valid bundle with trap_illegal=1 and all write enables 0.
- ECALL/EBREAK set trap_ecall_m/trap_ebreak; MRET sets mret=1.
- FENCE decodes as NOP.
- CSR write-enable rules: CSRRS/CSRRC with rs1=0 and CSRRSI/CSRRCI with zimm=0 do not write.
- M-ops: alu_op from funct3 when funct7=0000001; all 8 map to distinct alu_op_t values.
- Writes with rd=0 force regfile_we=0.
- FSM:
  - S_RUN -> S_WFI when WFI is accepted and EN_WFI=1.
  - S_RUN -> S_FENCEI when FENCE.I is accepted.
  - S_WFI -> S_RUN when i_irq_pending=1; a pending IRQ in the accept cycle still costs one S_WFI cycle.
  - S_FENCEI -> S_RUN when !o_valid && i_pipe_empty; o_fencei_req=1 in exactly that transition cycle.
  - Any state -> S_RUN on i_flush.
  - WFI and FENCE.I bundles themselves are emitted as NOP with wfi/fencei flags set.
- Reset mid-stall returns to S_RUN with o_valid=0 and no pulse.

Decomposition:
- cotm32_pkg:
  - cu_ctrl_t packed struct (alu_op, alu_a/b_sel, imm_sel, bu_be, bu_op, regfile_we, rd/rs1/rs2, lsu_ls, reg_wb_sel, csr_we/op/data_sel/addr/zimm, mret, wfi, fencei, trap_illegal/ecall_m/ebreak).
  - CU_CTRL_NOP constant.
  - cu_state_t enum {S_RUN, S_WFI, S_FENCEI}.
  - M funct3 constants and new alu_op_t members (ALU_MUL...ALU_REMU).
  - INST_EXACT_MRET, INST_EXACT_WFI.
- Sub-module cu_decode: purely combinational inst -> cu_ctrl_t, parameterised by EN_M/EN_ZICSR/EN_WFI. cu_pipe holds handshake, register and FSM.

Test Plan:
- Stream of ADDI x1,x0,5 (0x00500093), SUB, LW, SW, BEQ with i_ready=1 -> o_valid one cycle after each accept. For ADDI: rd=1, alu_op=ALU_ADD, imm_sel=IMM_I, regfile_we=1. Zero bubbles.
- i_ready=0 for 3 cycles with a held entry -> o_inst_ready=0, o_ctrl/o_pc unchanged. Release -> next instruction accepted the same cycle.
- MUL x3,x1,x2 (0x022081B3) with EN_M=1 -> alu_op=ALU_MUL. Same word with EN_M=0 -> trap_illegal=1, regfile_we=0.
- WFI (0x10500073), i_irq_pending asserted 4 cycles later -> o_inst_ready=0 throughout S_WFI, returns to 1 the cycle after the pending edge.
- FENCE.I (0x0000100F), then hold i_pipe_empty=0 for 2 cycles -> single o_fencei_req pulse once the entry retires and i_pipe_empty=1.
- i_flush during S_FENCEI with o_valid=1 -> next cycle o_valid=0, S_RUN, no o_fencei_req. CSRRS x5,mstatus,x0 -> csr_we=0, regfile_we=1.
